ps2_key_decoder: RTL and testbench



---
 rtl/ps2_key_decoder.sv | 168 ++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: synchronises and deglitches the raw pin pair, receives
// 11-bit frames, checks parity/stop, folds E0/F0 prefixes into an 11-bit key event.
`timescale 1ns/1ps

module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 12000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_REL = 8'hF0;

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_s;
  logic             data_s;

  logic             filt_clk;
  logic [FLT_W-1:0] flt_cnt;
  logic             strobe;

  logic [1:0]       state;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             parity_bit;
  logic [TMO_W-1:0] tmo_cnt;

  logic             frame_done;
  logic             frame_ok;
  logic             ext_flag;
  logic             rel_flag;

  // Both lines idle high, so the synchronisers reset to 1 to avoid a fake falling edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // blocking here would collapse the two synchroniser stages into one.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // The filtered clock follows the synchronised level only after FILTER_LEN
  // consecutive samples disagree with it; any agreeing sample restarts the run.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      filt_clk <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_s == filt_clk) begin
      flt_cnt  <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      filt_clk <= clk_s;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + FLT_W'(1);
    end
  end

  // Strobe fires in the cycle the filtered clock is about to fall.
  assign strobe = filt_clk && !clk_s && (flt_cnt == FLT_W'(FILTER_LEN - 1));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    if (strobe && state == ST_STOP) begin
      frame_done = 1'b1;
      frame_ok   = (^{shift_reg, parity_bit}) && data_s;
    end
  end

  // Frame receiver; a strobe always takes priority over the inactivity timeout.
  // NOTE: datapath registers are reset too -- there are no memory arrays here,
  // so clearing them costs nothing and keeps post-reset behaviour deterministic.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      tmo_cnt    <= '0;
    end else if (strobe) begin
      tmo_cnt <= '0;
      case (state)
        ST_IDLE: begin
          if (!data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          shift_reg <= {data_s, shift_reg[7:1]};
          if (bit_cnt == 3'd7) begin
            state <= ST_PARITY;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_bit <= data_s;
          state      <= ST_STOP;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end else if (state != ST_IDLE) begin
      if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
        state   <= ST_IDLE;
        bit_cnt <= '0;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Byte processing: prefixes only set flags; any other byte emits one event.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      ps2_key   <= 11'h000;
      frame_err <= 1'b0;
      ext_flag  <= 1'b0;
      rel_flag  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (frame_done) begin
        if (!frame_ok) begin
          frame_err <= 1'b1;
          ext_flag  <= 1'b0;
          rel_flag  <= 1'b0;
        end else if (shift_reg == CODE_EXT) begin
          ext_flag <= 1'b1;
        end else if (shift_reg == CODE_REL) begin
          rel_flag <= 1'b1;
        end else begin
          ps2_key  <= {~ps2_key[10], ~rel_flag, ext_flag, shift_reg};
          ext_flag <= 1'b0;
          rel_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scenarios plus random frames,
// expected events come from a byte-level model and are checked by a monitor.
`timescale 1ns/1ps

module tb_ps2_key_decoder;

  localparam int FL   = 4;
  localparam int TMO  = 300;
  localparam int HALF = 20;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;

  always #5 clk_sys = ~clk_sys;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TMO)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err)
  );

  typedef struct packed {
    logic        is_err;
    logic [10:0] key;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the last emitted word and the pending prefix flags.
  logic [10:0] m_key;
  logic        m_ext;
  logic        m_rel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_key = 11'h000;
    m_ext = 1'b0;
    m_rel = 1'b0;
  endtask

  task automatic model_frame(input logic [7:0] b, input logic good);
    exp_t e;
    if (!good) begin
      e.is_err = 1'b1;
      e.key    = m_key;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      m_key    = {~m_key[10], ~m_rel, m_ext, b};
      e.is_err = 1'b0;
      e.key    = m_key;
      exp_q.push_back(e);
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    model_frame(b, !(bad_par || bad_stop));
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ bad_par);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic wait_drained(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      wait_cyc(1);
      n++;
    end
  endtask

  // Monitor: any frame_err pulse or change of ps2_key is one observed event.
  initial begin : monitor
    logic [10:0] prev;
    exp_t        obs;
    exp_t        e;
    prev = 11'h000;
    forever begin
      @(negedge clk_sys);
      if (reset) begin
        prev = ps2_key;
      end else begin
        if (frame_err || ps2_key !== prev) begin
          obs.is_err = frame_err;
          obs.key    = ps2_key;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_event: got err=%b key=%h, expected no event (t=%0t)",
                     frame_err, ps2_key, $time);
          end else begin
            e = exp_q.pop_front();
            check("event", 32'(obs), 32'(e));
          end
        end
        prev = ps2_key;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] b;
    int         r;
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    wait_cyc(5);
    check("reset_key", 32'(ps2_key), 32'h000);
    check("reset_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    // Plain make code.
    send_frame(8'h1C, 1'b0, 1'b0);
    check("key_1c", 32'(ps2_key), 32'h61C);

    // Extended release: prefixes alone produce no event.
    send_frame(8'hE0, 1'b0, 1'b0);
    check("no_event_e0", 32'(ps2_key), 32'h61C);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("no_event_f0", 32'(ps2_key), 32'h61C);
    send_frame(8'h75, 1'b0, 1'b0);
    check("key_e0f0_75", 32'(ps2_key[9:0]), 32'h175);
    check("toggle_75", 32'(ps2_key[10]), 32'h0);

    // Bad parity clears the pending release prefix.
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h29, 1'b1, 1'b0);
    check("bad_frame_key_held", 32'(ps2_key), 32'h175);
    send_frame(8'h29, 1'b0, 1'b0);
    check("key_29_press", 32'(ps2_key[9:0]), 32'h229);

    // Sub-threshold glitch on the clock line while idle.
    ps2_clk = 1'b0;
    wait_cyc(FL - 1);
    ps2_clk = 1'b1;
    wait_cyc(30);
    check("glitch_no_event", 32'(ps2_key), 32'(m_key));

    // Partial frame abandoned by the timeout, then a clean frame.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    wait_cyc(TMO + 1);
    send_frame(8'h16, 1'b0, 1'b0);
    check("key_16_after_timeout", 32'(ps2_key[9:0]), 32'h216);

    // Randomised traffic with prefixes and corrupted frames mixed in.
    for (int n = 0; n < 40; n++) begin
      r = int'($urandom_range(0, 15));
      b = 8'($urandom);
      case (r)
        0:       send_frame(8'hE0, 1'b0, 1'b0);
        1:       send_frame(8'hF0, 1'b0, 1'b0);
        2:       send_frame(b, 1'b1, 1'b0);
        3:       send_frame(b, 1'b0, 1'b1);
        default: send_frame(b, 1'b0, 1'b0);
      endcase
    end
    wait_drained(200);
    check("random_drained", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset mid-frame.
    for (int i = 0; i < 5; i++) send_bit((i == 0) ? 1'b0 : 1'($urandom_range(0, 1)));
    @(negedge clk_sys);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_key", 32'(ps2_key), 32'h000);
    model_reset();
    exp_q.delete();
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(10);
    send_frame(8'h5A, 1'b0, 1'b0);
    check("key_5a_after_reset", 32'(ps2_key), 32'h65A);

    wait_drained(200);
    check("final_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
